// File: rtl/mesh_boot_eoc_pkg.sv
// Shared types and default sizes for the mesh boot / end-of-computation controller.
package mesh_boot_eoc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BOOT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int DEF_N_TILES = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_CODE_W  = 32;
  localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/mesh_eoc_tile_capture.sv
// Per-tile sticky EOC flag and first-seen exit code capture.
module mesh_eoc_tile_capture
  import mesh_boot_eoc_pkg::*;
#(
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_cap_en,
  input  logic              i_eoc,
  input  logic [CODE_W-1:0] i_code,
  output logic              o_seen_nxt,
  output logic [CODE_W-1:0] o_code_nxt
);

  logic              r_seen;
  logic [CODE_W-1:0] r_code;
  logic              w_cap;

  assign w_cap      = i_cap_en & i_eoc & ~r_seen;
  // Next-state view lets the parent act on a capture in the same cycle
  assign o_seen_nxt = r_seen | w_cap;
  assign o_code_nxt = w_cap ? i_code : r_code;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_seen <= 1'b0;
      r_code <= '0;
    end else if (w_cap) begin
      r_seen <= 1'b1;
      r_code <= i_code;
    end
  end

endmodule

// File: rtl/mesh_boot_eoc_ctrl.sv
// Boots a set of mesh tiles, waits for their EOCs (or a watchdog) and aggregates exit codes.
module mesh_boot_eoc_ctrl
  import mesh_boot_eoc_pkg::*;
#(
  parameter int N_TILES = DEF_N_TILES,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CODE_W  = DEF_CODE_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      clear_i,
  input  logic [ADDR_W-1:0]         boot_addr_i,
  input  logic [N_TILES-1:0]        tile_mask_i,
  input  logic [CNT_W-1:0]          timeout_i,
  input  logic [N_TILES-1:0]        tile_eoc_i,
  input  logic [N_TILES*CODE_W-1:0] tile_exit_code_i,
  output logic [N_TILES-1:0]        fetch_en_o,
  output logic [ADDR_W-1:0]         boot_addr_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CODE_W-1:0]         exit_code_o,
  output logic                      timeout_o,
  output logic [N_TILES-1:0]        fail_mask_o
);

  state_e               r_state;
  logic [N_TILES-1:0]   r_mask;
  logic [CNT_W-1:0]     r_to;
  logic [CNT_W-1:0]     r_cnt;
  logic [N_TILES-1:0]   r_fetch_en;
  logic [ADDR_W-1:0]    r_boot_addr;
  logic                 r_busy;
  logic                 r_done;
  logic [CODE_W-1:0]    r_exit;
  logic                 r_tmo;
  logic [N_TILES-1:0]   r_fail;

  logic                 w_clr;
  logic [N_TILES-1:0]   w_cap_en;
  logic [N_TILES-1:0]   w_seen_nxt;
  logic [CODE_W-1:0]    w_code_nxt [N_TILES];
  logic                 w_complete;
  logic                 w_tmo;
  logic [CODE_W-1:0]    w_exit;
  logic [N_TILES-1:0]   w_fail;

  // Captures are wiped on reset, abort, and at the start of every run
  assign w_clr    = rst_i | clear_i | ((r_state == S_IDLE) & start_i);
  assign w_cap_en = (r_state == S_RUN) ? r_mask : '0;

  for (genvar k = 0; k < N_TILES; k++) begin : g_tile
    mesh_eoc_tile_capture #(
      .CODE_W(CODE_W)
    ) u_cap (
      .i_clk      (clk_i),
      .i_clr      (w_clr),
      .i_cap_en   (w_cap_en[k]),
      .i_eoc      (tile_eoc_i[k]),
      .i_code     (tile_exit_code_i[k*CODE_W +: CODE_W]),
      .o_seen_nxt (w_seen_nxt[k]),
      .o_code_nxt (w_code_nxt[k])
    );
  end

  assign w_complete = ((w_seen_nxt & r_mask) == r_mask);
  assign w_tmo      = (r_to != '0) && (r_cnt == r_to - CNT_W'(1));

  always_comb begin
    w_exit = '0;
    w_fail = '0;
    for (int k = 0; k < N_TILES; k++) begin
      if (r_mask[k] & w_seen_nxt[k]) w_exit = w_exit | w_code_nxt[k];
      w_fail[k] = r_mask[k] & (~w_seen_nxt[k] | (|w_code_nxt[k]));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_to        <= '0;
      r_cnt       <= '0;
      r_fetch_en  <= '0;
      r_boot_addr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_exit      <= '0;
      r_tmo       <= 1'b0;
      r_fail      <= '0;
    end else if (clear_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_fetch_en <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_exit     <= '0;
      r_tmo      <= 1'b0;
      r_fail     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_boot_addr <= boot_addr_i;
            r_mask      <= tile_mask_i;
            r_to        <= timeout_i;
            r_exit      <= '0;
            r_fail      <= '0;
            r_tmo       <= 1'b0;
            if (tile_mask_i != '0) begin
              r_state <= S_BOOT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_BOOT: begin
          r_state    <= S_RUN;
          r_fetch_en <= r_mask;
          r_cnt      <= '0;
        end
        S_RUN: begin
          if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
          if (w_complete || w_tmo) begin
            r_state    <= S_DONE;
            r_fetch_en <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_exit     <= w_exit;
            r_fail     <= w_fail;
            r_tmo      <= ~w_complete;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fetch_en_o  = r_fetch_en;
  assign boot_addr_o = r_boot_addr;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign exit_code_o = r_exit;
  assign timeout_o   = r_tmo;
  assign fail_mask_o = r_fail;

endmodule

// File: doc/mesh_boot_eoc_ctrl.md
MESH_BOOT_EOC_CTRL -- requirements
Module: mesh_boot_eoc_ctrl

Interface
REQ-001 SHALL have parameter N_TILES, default 4, number of mesh tiles controlled (1..64).
REQ-002 SHALL have parameter ADDR_W, default 32, boot address width.
REQ-003 SHALL have parameter CODE_W, default 32, per-tile exit code width.
REQ-004 SHALL have parameter CNT_W, default 32, watchdog counter width.
REQ-005 SHALL use one clock and a synchronous, active-high reset; ports clk_i and rst_i.
REQ-006 Ports, one per line:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  single-cycle run request
clear_i  in  1  return to IDLE / abort run
boot_addr_i  in  ADDR_W  boot address for this run
tile_mask_i  in  N_TILES  participating tiles
timeout_i  in  CNT_W  watchdog limit in RUN cycles; 0 = disabled
tile_eoc_i  in  N_TILES  per-tile end-of-computation, level or pulse
tile_exit_code_i  in  N_TILES*CODE_W  per-tile exit code, tile k at [k*CODE_W +: CODE_W]
fetch_en_o  out  N_TILES  per-tile fetch enable
boot_addr_o  out  ADDR_W  boot address driven to all tiles
busy_o  out  1  high in BOOT or RUN
done_o  out  1  high in DONE
exit_code_o  out  CODE_W  aggregated exit code
timeout_o  out  1  run ended by watchdog
fail_mask_o  out  N_TILES  masked tiles with nonzero code or no EOC

Function
REQ-007 SHALL implement FSM states IDLE, BOOT, RUN, DONE; all outputs registered.
REQ-008 IDLE: start_i=1 with nonzero tile_mask_i SHALL latch boot_addr_i, tile_mask_i, timeout_i and enter BOOT next cycle.
REQ-009 IDLE: start_i=1 with tile_mask_i=0 SHALL enter DONE next cycle with exit_code_o=0, fail_mask_o=0, timeout_o=0.
REQ-010 BOOT SHALL last exactly one cycle: boot_addr_o valid, fetch_en_o=0; then RUN.
REQ-011 RUN: fetch_en_o SHALL equal latched mask; watchdog counter starts at 0 on RUN entry, increments every RUN cycle.
REQ-012 RUN: first cycle tile_eoc_i[k]=1 for masked tile k SHALL set sticky seen[k] and capture tile k exit code; later EOCs/code changes for k SHALL be ignored.
REQ-013 EOC of unmasked tiles, and any EOC outside RUN, SHALL be ignored.
REQ-014 When seen equals mask (including capture in the current cycle), SHALL enter DONE next cycle, timeout_o=0.
REQ-015 Timeout: when timeout nonzero and counter equals timeout-1 without completion, SHALL enter DONE next cycle with timeout_o=1.
REQ-016 Completion and timeout in the same cycle: completion SHALL win, timeout_o=0.
REQ-017 Counter SHALL saturate at all-ones, never wrap.
REQ-018 DONE: fetch_en_o=0; exit_code_o = bitwise OR of captured codes over masked seen tiles; fail_mask_o = mask & (~seen | nonzero-code); held until clear_i.
REQ-019 start_i in BOOT, RUN or DONE SHALL be ignored.
REQ-020 clear_i in any state SHALL enter IDLE next cycle, drop fetch_en_o, clear seen, captures, counter, done_o, timeout_o, exit_code_o, fail_mask_o; clear_i has priority over start_i and completion.

Reset
REQ-021 rst_i SHALL force IDLE; fetch_en_o=0, boot_addr_o=0, busy_o=0, done_o=0, exit_code_o=0, timeout_o=0, fail_mask_o=0, seen=0, counter=0.
REQ-022 rst_i mid-RUN SHALL deassert fetch_en_o the following cycle; no partial result retained.

Structure
REQ-023 Package mesh_boot_eoc_pkg SHALL hold the state enum and default parameter constants.
REQ-024 Per-tile sticky EOC flag and code register SHALL be sub-module mesh_eoc_tile_capture, generated N_TILES times.

Verification
REQ-025 Mask 4'b1111, boot 0xCC00_0000, timeout 0, tiles EOC at RUN cycles 10/20/30/40 codes 0 -> fetch_en 1111 after 1 BOOT cycle, done_o cycle after 40, exit_code 0, fail_mask 0.
REQ-026 Mask 4'b0101, tile1 EOC code 0xFF, tile2 code 0x3, tile0 code 0x4 -> tile1 ignored, exit_code 0x7, fail_mask 0101.
REQ-027 Mask 4'b0011, timeout 100, only tile0 EOCs -> DONE after 100 RUN cycles, timeout_o=1, fail_mask 0010.
REQ-028 Last EOC arrives on counter=timeout-1 -> timeout_o=0, done_o=1.
REQ-029 clear_i at RUN cycle 5, then start_i mask 0 -> IDLE, fetch_en 0, then DONE with exit_code 0.
REQ-030 rst_i at RUN cycle 7 -> all outputs at reset values next cycle; re-start completes normally.
